// File: rtl/uart_bist_pkg.sv
// Shared types and the pattern next-value rule for the UART self-test sequencer.
package uart_bist_pkg;

    typedef enum logic [1:0] {StIdle, StFlush, StRun, StDone} state_e;

    typedef enum logic [1:0] {ModeConst, ModeInc, ModeRotl, ModeAlt} mode_e;

    localparam int unsigned MaxBits = 32;

    // Works on a MaxBits container; only the low `width` bits are meaningful.
    function automatic logic [MaxBits-1:0] pattern_next(input mode_e mode,
                                                        input logic [MaxBits-1:0] x,
                                                        input int unsigned width);
        logic [MaxBits-1:0] mask;
        logic [MaxBits-1:0] r;
        for (int unsigned i = 0; i < MaxBits; i++) begin
            mask[i] = (i < width);
        end
        case (mode)
            ModeConst: r = x;
            ModeInc:   r = x + MaxBits'(1);
            ModeRotl:  r = (x << 1) | ((x >> (width - 1)) & MaxBits'(1));
            ModeAlt:   r = ~x;
            default:   r = x;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/uart_pattern_gen.sv
// Byte-pattern generator: loads a seed, steps to the next value on advance.
module uart_pattern_gen
    import uart_bist_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 advance_i,
    input  mode_e                mode_i,
    input  logic [DATA_BITS-1:0] seed_i,
    output logic [DATA_BITS-1:0] value_o
);

    logic [DATA_BITS-1:0] value_q, value_d, value_next;

    assign value_next = DATA_BITS'(pattern_next(mode_i, MaxBits'(value_q), DATA_BITS));

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = seed_i;
        end else if (advance_i) begin
            value_d = value_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/uart_bist.sv
// UART built-in self-test: flush RX, push a generated burst, check the looped-back bytes.
module uart_bist
    import uart_bist_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned BURST_LEN      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    localparam int unsigned CW            = $clog2(BURST_LEN + 1)
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Start,
    input  logic [1:0]           Mode,
    input  logic [DATA_BITS-1:0] Seed,
    output logic                 WriteUart,
    output logic [DATA_BITS-1:0] WriteData,
    input  logic                 TxFull,
    output logic                 ReadUart,
    input  logic [DATA_BITS-1:0] ReadData,
    input  logic                 RxEmpty,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Pass,
    output logic                 Timeout,
    output logic [CW-1:0]        ErrCount,
    output logic [CW-1:0]        FirstErrIdx,
    output logic [DATA_BITS-1:0] LastRx
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BurstLen = CW'(BURST_LEN);
    localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT_CYCLES);

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [CW-1:0]        tx_sent_q, tx_sent_d;
    logic [CW-1:0]        rx_got_q, rx_got_d;
    logic [CW-1:0]        err_q, err_d;
    logic [CW-1:0]        first_q, first_d;
    logic [DATA_BITS-1:0] last_rx_q, last_rx_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 pass_q, pass_d;
    logic                 timeout_q, timeout_d;
    logic                 wr_last_q, rd_last_q;
    logic                 wr_en, rd_en, rx_take, load;
    logic [DATA_BITS-1:0] tx_value, exp_value;

    uart_pattern_gen #(.DATA_BITS(DATA_BITS)) u_tx_gen (
        .clk_i    (Clock),
        .rst_ni   (ResetN),
        .load_i   (load),
        .advance_i(wr_en),
        .mode_i   (mode_q),
        .seed_i   (Seed),
        .value_o  (tx_value)
    );

    uart_pattern_gen #(.DATA_BITS(DATA_BITS)) u_exp_gen (
        .clk_i    (Clock),
        .rst_ni   (ResetN),
        .load_i   (load),
        .advance_i(rx_take),
        .mode_i   (mode_q),
        .seed_i   (Seed),
        .value_o  (exp_value)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        tx_sent_d = tx_sent_q;
        rx_got_d  = rx_got_q;
        err_d     = err_q;
        first_d   = first_q;
        last_rx_d = last_rx_q;
        tmo_d     = tmo_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rx_take   = 1'b0;
        load      = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    state_d   = StFlush;
                    mode_d    = mode_e'(Mode);
                    tx_sent_d = '0;
                    rx_got_d  = '0;
                    err_d     = '0;
                    first_d   = BurstLen;
                    tmo_d     = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    load      = 1'b1;
                end
            end
            StFlush: begin
                // Flags lag a pop by one cycle, so only trust RxEmpty on a quiet cycle.
                if (!rd_last_q) begin
                    if (!RxEmpty) begin
                        rd_en = 1'b1;
                    end else begin
                        state_d = StRun;
                        tmo_d   = '0;
                    end
                end
            end
            StRun: begin
                if (tx_sent_q < BurstLen && !TxFull && !wr_last_q) begin
                    wr_en     = 1'b1;
                    tx_sent_d = tx_sent_q + CW'(1);
                end
                tmo_d = tmo_q + TW'(1);
                if (!RxEmpty && !rd_last_q) begin
                    rd_en     = 1'b1;
                    rx_take   = 1'b1;
                    tmo_d     = '0;
                    last_rx_d = ReadData;
                    rx_got_d  = rx_got_q + CW'(1);
                    if (ReadData != exp_value) begin
                        if (err_q != '1) begin
                            err_d = err_q + CW'(1);
                        end
                        if (first_q == BurstLen) begin
                            first_d = rx_got_q;
                        end
                    end
                end
                if (rx_got_d == BurstLen) begin
                    state_d = StDone;
                    pass_d  = (err_d == '0);
                end else if (tmo_d == TimeoutMax) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q   <= StIdle;
            mode_q    <= ModeConst;
            tx_sent_q <= '0;
            rx_got_q  <= '0;
            err_q     <= '0;
            first_q   <= BurstLen;
            last_rx_q <= '0;
            tmo_q     <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            wr_last_q <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            tx_sent_q <= tx_sent_d;
            rx_got_q  <= rx_got_d;
            err_q     <= err_d;
            first_q   <= first_d;
            last_rx_q <= last_rx_d;
            tmo_q     <= tmo_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            wr_last_q <= wr_en;
            rd_last_q <= rd_en;
        end
    end

    // Strobes are gated by reset so nothing reaches the FIFOs while reset is held.
    assign WriteUart   = wr_en & ResetN;
    assign ReadUart    = rd_en & ResetN;
    assign WriteData   = tx_value;
    assign Busy        = (state_q == StFlush) || (state_q == StRun);
    assign Done        = (state_q == StDone);
    assign Pass        = pass_q;
    assign Timeout     = timeout_q;
    assign ErrCount    = err_q;
    assign FirstErrIdx = first_q;
    assign LastRx      = last_rx_q;

endmodule

// File: tb/tb_uart_bist.sv
// Self-checking bench for uart_bist: loopback model with 4-deep FIFOs and a 20-cycle wire.
module tb_uart_bist;

    localparam int BL  = 4;
    localparam int TMO = 1000;

    logic       Clock = 1'b0;
    logic       ResetN, Start, WriteUart, TxFull, ReadUart, RxEmpty;
    logic       Busy, Done, Pass, Timeout;
    logic [1:0] Mode;
    logic [7:0] Seed, WriteData, ReadData, LastRx;
    logic [2:0] ErrCount, FirstErrIdx;

    always #5 Clock = ~Clock;

    uart_bist #(
        .DATA_BITS     (8),
        .BURST_LEN     (BL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .Start      (Start),
        .Mode       (Mode),
        .Seed       (Seed),
        .WriteUart  (WriteUart),
        .WriteData  (WriteData),
        .TxFull     (TxFull),
        .ReadUart   (ReadUart),
        .ReadData   (ReadData),
        .RxEmpty    (RxEmpty),
        .Busy       (Busy),
        .Done       (Done),
        .Pass       (Pass),
        .Timeout    (Timeout),
        .ErrCount   (ErrCount),
        .FirstErrIdx(FirstErrIdx),
        .LastRx     (LastRx)
    );

    int checks = 0;
    int failures = 0;

    // Loopback model state
    logic [7:0] tx_q[$], rx_q[$], tx_log[$], rx_log[$];
    logic       wire_busy = 1'b0;
    int         wire_left = 0;
    logic [7:0] wire_byte = 8'h00;
    int         n_sent = 0, drop_idx = -1, flip_idx = -1;
    logic [7:0] flip_mask = 8'h00;
    int         full_at = 0, full_left = 0;
    bit         forced = 1'b0, force_full = 1'b0;
    int         cyc = 0, last_pop_cyc = 0, done_cyc = 0;
    logic       wr_s = 1'b0, rd_s = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;
    logic [7:0] wd_s = 8'h00;
    int         strobe_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ref_next(input int mode, input logic [7:0] x);
        case (mode)
            0:       return x;
            1:       return x + 8'd1;
            2:       return (x << 1) | (x >> 7);
            default: return ~x;
        endcase
    endfunction

    function automatic void update_flags();
        TxFull   = force_full || (tx_q.size() >= 4);
        RxEmpty  = (rx_q.size() == 0);
        ReadData = RxEmpty ? 8'h00 : rx_q[0];
    endfunction

    function automatic void clear_model();
        tx_q.delete();
        rx_q.delete();
        tx_log.delete();
        rx_log.delete();
        wire_busy = 1'b0;
        wire_left = 0;
        n_sent    = 0;
        forced    = 1'b0;
        full_left = 0;
        force_full = 1'b0;
        update_flags();
    endfunction

    // Strobe capture and protocol checks, mid-cycle
    always @(negedge Clock) begin
        if (WriteUart) check("wr_protocol_prev_or_full", {30'd0, prev_wr, TxFull}, 32'd0);
        if (ReadUart) check("rd_protocol_prev_or_empty", {30'd0, prev_rd, RxEmpty}, 32'd0);
        if (WriteUart || ReadUart) strobe_cnt++;
        prev_wr = WriteUart;
        prev_rd = ReadUart;
        wr_s    = WriteUart;
        wd_s    = WriteData;
        rd_s    = ReadUart;
    end

    // FIFO + wire update just after each edge
    always @(posedge Clock) begin
        logic [7:0] b;
        #1;
        cyc++;
        if (wr_s) begin
            if (tx_q.size() < 4) tx_q.push_back(wd_s);
            tx_log.push_back(wd_s);
        end
        if (rd_s && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            last_pop_cyc = cyc;
        end
        if (wire_busy) begin
            wire_left--;
            if (wire_left == 0) begin
                wire_busy = 1'b0;
                if (n_sent != drop_idx) begin
                    b = wire_byte ^ ((n_sent == flip_idx) ? flip_mask : 8'h00);
                    if (rx_q.size() < 4) rx_q.push_back(b);
                    rx_log.push_back(b);
                end
                n_sent++;
            end
        end else if (tx_q.size() > 0) begin
            wire_byte = tx_q.pop_front();
            wire_busy = 1'b1;
            wire_left = 20;
        end
        if (full_at > 0 && !forced && tx_log.size() >= full_at) begin
            forced    = 1'b1;
            full_left = 100;
        end
        force_full = (full_left > 0);
        if (full_left > 0) full_left--;
        update_flags();
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_done"}, 32'(Done), 0);
        check({tag, "_pass"}, 32'(Pass), 0);
        check({tag, "_timeout"}, 32'(Timeout), 0);
        check({tag, "_errcount"}, 32'(ErrCount), 0);
        check({tag, "_firsterridx"}, 32'(FirstErrIdx), BL);
        check({tag, "_lastrx"}, 32'(LastRx), 0);
        check({tag, "_writeuart"}, 32'(WriteUart), 0);
        check({tag, "_readuart"}, 32'(ReadUart), 0);
        check({tag, "_writedata"}, 32'(WriteData), 0);
    endtask

    task automatic do_run(input string tag, input int mode, input int seed, input int fi,
                          input int fm, input int di, input int stale_n, input int fa);
        logic [7:0] expv[BL];
        int         err, first, n, gap;
        bit         got, tmo_exp;
        logic [7:0] last_exp;
        @(negedge Clock);
        clear_model();
        flip_idx  = fi;
        flip_mask = 8'(fm);
        drop_idx  = di;
        full_at   = fa;
        for (int k = 0; k < stale_n; k++) begin
            rx_q.push_back(k == 0 ? 8'hAA : (k == 1 ? 8'hBB : 8'($urandom_range(0, 255))));
        end
        update_flags();
        expv[0] = 8'(seed);
        for (int i = 1; i < BL; i++) expv[i] = ref_next(mode, expv[i-1]);
        Mode  = 2'(mode);
        Seed  = 8'(seed);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        Mode  = 2'($urandom_range(0, 3));
        Seed  = 8'($urandom_range(0, 255));
        check({tag, "_busy_after_start"}, 32'(Busy), 1);
        check({tag, "_done_cleared"}, 32'(Done), 0);
        repeat (3) @(negedge Clock);
        Seed  = 8'(seed) ^ 8'h55;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge Clock);
            if (Done) begin
                got      = 1'b1;
                done_cyc = cyc;
            end
        end
        check({tag, "_done_reached"}, 32'(got), 1);
        check({tag, "_busy_low_at_done"}, 32'(Busy), 0);
        check({tag, "_tx_count"}, tx_log.size(), BL);
        for (int i = 0; i < BL; i++) begin
            check({tag, "_tx_byte"}, 32'(i < tx_log.size() ? tx_log[i] : 8'hxx), 32'(expv[i]));
        end
        n     = rx_log.size();
        err   = 0;
        first = BL;
        for (int i = 0; i < n && i < BL; i++) begin
            if (rx_log[i] != expv[i]) begin
                err++;
                if (first == BL) first = i;
            end
        end
        last_exp = (n > 0) ? rx_log[(n < BL ? n : BL) - 1] : 8'h00;
        tmo_exp  = (n < BL);
        check({tag, "_errcount"}, 32'(ErrCount), err);
        check({tag, "_firsterridx"}, 32'(FirstErrIdx), first);
        check({tag, "_lastrx"}, 32'(LastRx), 32'(last_exp));
        check({tag, "_timeout"}, 32'(Timeout), 32'(tmo_exp));
        check({tag, "_pass"}, 32'(Pass), 32'(!tmo_exp && err == 0));
        if (tmo_exp) begin
            gap = done_cyc - last_pop_cyc;
            check({tag, "_timeout_gap_near_1000"}, 32'(gap >= TMO - 5 && gap <= TMO + 5), 1);
        end
    endtask

    initial begin
        ResetN = 1'b0;
        Start  = 1'b0;
        Mode   = 2'd0;
        Seed   = 8'd0;
        update_flags();
        repeat (3) @(negedge Clock);
        check_reset_values("reset");
        ResetN = 1'b1;

        // Increment, clean loop
        do_run("inc_clean", 1, 8'h3C, -1, 0, -1, 0, 0);
        check("inc_clean_tx_literal", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h3C3D3E3F);
        check("inc_clean_lastrx_literal", 32'(LastRx), 32'h3F);
        check("inc_clean_pass_literal", 32'(Pass), 1);

        // Rotate-left, bit 0 of the second returned byte flipped
        do_run("rotl_flip", 2, 8'h81, 1, 8'h01, -1, 0, 0);
        check("rotl_flip_tx_literal", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h8103060C);
        check("rotl_flip_err_literal", {29'd0, ErrCount}, 1);
        check("rotl_flip_first_literal", {29'd0, FirstErrIdx}, 1);

        // Third byte dropped on the wire
        do_run("drop_timeout", 1, $urandom_range(0, 255), -1, 0, 2, 0, 0);
        check("drop_timeout_flag_literal", 32'(Timeout), 1);

        // Stale bytes flushed before the run
        do_run("stale_alt", 3, 8'h0F, -1, 0, -1, 2, 0);
        check("stale_alt_tx_literal", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h0FF00FF0);
        check("stale_alt_lastrx_literal", 32'(LastRx), 32'hF0);

        // TX FIFO held full for 100 cycles after the second push
        do_run("txfull_hold", 1, $urandom_range(0, 255), -1, 0, -1, 0, 2);
        check("txfull_hold_pass_literal", 32'(Pass), 1);

        for (int r = 0; r < 4; r++) begin
            do_run("random", $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 5),
                   $urandom_range(1, 255), -1, $urandom_range(0, 3), 0);
        end

        // Reset mid-run
        @(negedge Clock);
        clear_model();
        Mode  = 2'd1;
        Seed  = 8'h20;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (40) @(negedge Clock);
        check("midrun_busy_before_reset", 32'(Busy), 1);
        ResetN = 1'b0;
        @(negedge Clock);
        ResetN = 1'b1;
        check_reset_values("midrun_reset");
        strobe_cnt = 0;
        repeat (60) @(negedge Clock);
        check("midrun_no_strobes_after_reset", strobe_cnt, 0);
        check("midrun_still_idle", 32'(Busy), 0);

        do_run("after_reset", $urandom_range(0, 3), $urandom_range(0, 255), -1, 0, -1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
